// File: rtl/rr_onehot_arbiter.sv
// Registered one-hot arbiter with fixed-priority or round-robin selection.
// A grant is held until the holder releases explicitly or drops its request.
module rr_onehot_arbiter #(
    parameter int DEPTH = 8,
    parameter int BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter bit RR    = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [DEPTH-1:0] i_req,
    input  logic             i_release,
    output logic [DEPTH-1:0] o_grant,
    output logic [BITS-1:0]  o_grant_idx,
    output logic             o_grant_valid,
    output logic [BITS-1:0]  o_ptr,
    output logic [0:0]       o_state
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [DEPTH-1:0] r_grant;
    logic [BITS-1:0]  r_grant_idx;
    logic             r_grant_valid;
    logic [BITS-1:0]  r_ptr;

    logic             w_rel_eff;
    logic [BITS-1:0]  w_next_ptr;
    logic [BITS-1:0]  w_scan_ptr;
    logic [DEPTH-1:0] w_masked;
    logic             w_found;
    logic [BITS-1:0]  w_win_idx;
    logic [DEPTH-1:0] w_win_onehot;
    logic [BITS-1:0]  w_cand;
    int               w_j;

    // Releasing and re-arbitrating happen in one cycle, so the scan starts from the
    // pointer value that is about to be written and skips the outgoing holder.
    always_comb begin
        w_rel_eff  = i_release | ~i_req[r_grant_idx];
        w_next_ptr = (r_grant_idx == BITS'(DEPTH - 1)) ? '0 : r_grant_idx + BITS'(1);
        w_scan_ptr = (RR && (r_state == S_HOLD)) ? w_next_ptr : r_ptr;
        w_masked   = (r_state == S_HOLD) ? (i_req & ~r_grant) : i_req;
        w_found    = 1'b0;
        w_win_idx  = '0;
        w_cand     = '0;
        w_j        = 0;
        for (int k = 0; k < DEPTH; k++) begin
            w_j = int'(w_scan_ptr) + k;
            if (w_j >= DEPTH) begin
                w_j = w_j - DEPTH;
            end
            w_cand = BITS'(w_j);
            if (!w_found && w_masked[w_cand]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand;
            end
        end
        w_win_onehot = '0;
        if (w_found) begin
            w_win_onehot[w_win_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_ptr         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_en && w_found) begin
                        r_state       <= S_HOLD;
                        r_grant       <= w_win_onehot;
                        r_grant_idx   <= w_win_idx;
                        r_grant_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_rel_eff) begin
                        if (RR) begin
                            r_ptr <= w_next_ptr;
                        end
                        if (i_en && w_found) begin
                            r_grant     <= w_win_onehot;
                            r_grant_idx <= w_win_idx;
                        end else begin
                            r_state       <= S_IDLE;
                            r_grant       <= '0;
                            r_grant_idx   <= '0;
                            r_grant_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_grant       <= '0;
                    r_grant_idx   <= '0;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_idx   = r_grant_idx;
    assign o_grant_valid = r_grant_valid;
    assign o_ptr         = r_ptr;
    assign o_state       = r_state;

    a_grant_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(r_grant));
    a_valid_matches: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_grant_valid == (|r_grant));
    a_idx_matches: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_grant[r_grant_idx] == r_grant_valid);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: three instances (8/RR, 8/fixed, 5/RR) share clock and reset.
// Expected {grant, valid, idx, ptr} tuples are queued per step and popped after each edge.
module tb_rr_onehot_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_en, a_rel, a_valid;
    logic [7:0] a_req, a_grant;
    logic [2:0] a_idx, a_ptr;
    logic [0:0] a_state;

    logic       b_en, b_rel, b_valid;
    logic [7:0] b_req, b_grant;
    logic [2:0] b_idx, b_ptr;
    logic [0:0] b_state;

    logic       c_en, c_rel, c_valid;
    logic [4:0] c_req, c_grant;
    logic [2:0] c_idx, c_ptr;
    logic [0:0] c_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [14:0] exp_q[$];

    rr_onehot_arbiter #(.DEPTH(8), .RR(1'b1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .i_req(a_req), .i_release(a_rel),
        .o_grant(a_grant), .o_grant_idx(a_idx), .o_grant_valid(a_valid), .o_ptr(a_ptr),
        .o_state(a_state)
    );

    rr_onehot_arbiter #(.DEPTH(8), .RR(1'b0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_req(b_req), .i_release(b_rel),
        .o_grant(b_grant), .o_grant_idx(b_idx), .o_grant_valid(b_valid), .o_ptr(b_ptr),
        .o_state(b_state)
    );

    rr_onehot_arbiter #(.DEPTH(5), .RR(1'b1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(c_en), .i_req(c_req), .i_release(c_rel),
        .o_grant(c_grant), .o_grant_idx(c_idx), .o_grant_valid(c_valid), .o_ptr(c_ptr),
        .o_state(c_state)
    );

    function automatic logic [14:0] mk_exp(input logic v, input logic [2:0] i, input logic [2:0] p);
        logic [7:0] g;
        g = v ? (8'd1 << i) : 8'd0;
        return {g, v, i, p};
    endfunction

    function automatic logic [14:0] obs_a();
        return {a_grant, a_valid, a_idx, a_ptr};
    endfunction

    function automatic logic [14:0] obs_b();
        return {b_grant, b_valid, b_idx, b_ptr};
    endfunction

    function automatic logic [14:0] obs_c();
        return {3'b000, c_grant, c_valid, c_idx, c_ptr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] exp;
        rst_n = 1'b0;
        a_en = 0; a_req = '0; a_rel = 0;
        b_en = 0; b_req = '0; b_rel = 0;
        c_en = 0; c_req = '0; c_rel = 0;
        #3;
        exp_q.push_back(mk_exp(0, 0, 0));
        exp = exp_q.pop_front();
        n_checks++;
        if (obs_a() !== exp) $display("FAIL reset_a: got %h want %h", obs_a(), exp);
        else n_pass++;
        n_checks++;
        if (obs_b() !== exp) $display("FAIL reset_b: got %h want %h", obs_b(), exp);
        else n_pass++;
        n_checks++;
        if (obs_c() !== exp) $display("FAIL reset_c: got %h want %h", obs_c(), exp);
        else n_pass++;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(mk_exp(0, 0, 0));
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== exp) $display("FAIL idle_after_reset cyc %0d: got %h want %h", k, obs_a(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_rr_rotation();
        logic [14:0] exp;
        a_en = 1; a_req = 8'hFF; a_rel = 0;
        exp_q.push_back(mk_exp(1, 0, 0));
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs_a() !== exp) $display("FAIL rr_first_grant: got %h want %h", obs_a(), exp);
        else n_pass++;
        a_rel = 1;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(mk_exp(1, 3'(k % 8), 3'(k % 8)));
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== exp) $display("FAIL rr_rotation step %0d: got %h want %h", k, obs_a(), exp);
            else n_pass++;
        end
        a_rel = 0; a_req = '0;
        exp_q.push_back(mk_exp(0, 0, 1));
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs_a() !== exp) $display("FAIL rr_to_idle: got %h want %h", obs_a(), exp);
        else n_pass++;
    endtask

    task automatic test_implicit_release();
        logic [14:0] exp;
        logic [7:0] req_tab[5];
        logic [14:0] exp_tab[5];
        req_tab = '{8'b0000_1000, 8'b0000_0010, 8'b0000_0010, 8'b0000_0010, 8'b0000_0000};
        exp_tab = '{mk_exp(1, 3, 1), mk_exp(1, 1, 4), mk_exp(1, 1, 4), mk_exp(1, 1, 4), mk_exp(0, 0, 2)};
        a_en = 1; a_rel = 0;
        for (int k = 0; k < 5; k++) begin
            a_req = req_tab[k];
            exp_q.push_back(exp_tab[k]);
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== exp) $display("FAIL implicit_release step %0d: got %h want %h", k, obs_a(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_fixed_priority();
        logic [14:0] exp;
        logic en_tab[10];
        logic rel_tab[10];
        logic [14:0] exp_tab[10];
        en_tab  = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 1};
        rel_tab = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0};
        exp_tab = '{mk_exp(1, 2, 0), mk_exp(0, 0, 0), mk_exp(1, 2, 0), mk_exp(0, 0, 0),
                    mk_exp(1, 2, 0), mk_exp(0, 0, 0), mk_exp(1, 2, 0), mk_exp(1, 5, 0),
                    mk_exp(1, 2, 0), mk_exp(0, 0, 0)};
        b_req = 8'b1010_0100;
        for (int k = 0; k < 10; k++) begin
            b_en  = en_tab[k];
            b_rel = rel_tab[k];
            if (k == 9) b_req = '0;
            exp_q.push_back(exp_tab[k]);
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (obs_b() !== exp) $display("FAIL fixed_priority step %0d: got %h want %h", k, obs_b(), exp);
            else n_pass++;
        end
        b_en = 0; b_rel = 0;
    endtask

    task automatic test_npot_wrap();
        logic [14:0] exp;
        logic [4:0] req_tab[12];
        logic rel_tab[12];
        logic [14:0] exp_tab[12];
        req_tab = '{5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001,
                    5'b00000, 5'b11000, 5'b11000, 5'b11000, 5'b00000};
        rel_tab = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0};
        exp_tab = '{mk_exp(1, 0, 0), mk_exp(1, 4, 1), mk_exp(1, 4, 1), mk_exp(1, 0, 0),
                    mk_exp(1, 0, 0), mk_exp(1, 4, 1), mk_exp(1, 0, 0), mk_exp(0, 0, 1),
                    mk_exp(1, 3, 1), mk_exp(1, 4, 4), mk_exp(1, 3, 0), mk_exp(0, 0, 4)};
        c_en = 1;
        for (int k = 0; k < 12; k++) begin
            c_req = req_tab[k];
            c_rel = rel_tab[k];
            exp_q.push_back(exp_tab[k]);
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (obs_c() !== exp) $display("FAIL npot_wrap step %0d: got %h want %h", k, obs_c(), exp);
            else n_pass++;
        end
        c_en = 0; c_rel = 0;
    endtask

    task automatic test_en_gating_hold();
        logic [14:0] exp;
        logic en_tab[6];
        logic rel_tab[6];
        logic [14:0] exp_tab[6];
        en_tab  = '{1, 0, 0, 0, 0, 0};
        rel_tab = '{0, 0, 0, 1, 1, 1};
        exp_tab = '{mk_exp(1, 2, 2), mk_exp(1, 2, 2), mk_exp(1, 2, 2),
                    mk_exp(0, 0, 3), mk_exp(0, 0, 3), mk_exp(0, 0, 3)};
        a_req = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            a_en  = en_tab[k];
            a_rel = rel_tab[k];
            exp_q.push_back(exp_tab[k]);
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== exp) $display("FAIL en_gating_hold step %0d: got %h want %h", k, obs_a(), exp);
            else n_pass++;
        end
        a_rel = 0;
    endtask

    task automatic test_reset_mid_grant();
        logic [14:0] exp;
        a_en = 1; a_req = 8'h40; a_rel = 0;
        exp_q.push_back(mk_exp(1, 6, 3));
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs_a() !== exp) $display("FAIL hold_idx6: got %h want %h", obs_a(), exp);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk_exp(0, 0, 0));
        exp = exp_q.pop_front();
        n_checks++;
        if (obs_a() !== exp) $display("FAIL async_reset_drop: got %h want %h", obs_a(), exp);
        else n_pass++;
        a_en = 0; a_req = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk_exp(0, 0, 0));
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== exp) $display("FAIL en_low_no_grant cyc %0d: got %h want %h", k, obs_a(), exp);
            else n_pass++;
        end
        a_en = 1;
        exp_q.push_back(mk_exp(1, 0, 0));
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs_a() !== exp) $display("FAIL en_rise_grant: got %h want %h", obs_a(), exp);
        else n_pass++;
        a_rel = 1;
        exp_q.push_back(mk_exp(1, 1, 1));
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs_a() !== exp) $display("FAIL restart_handover: got %h want %h", obs_a(), exp);
        else n_pass++;
        a_rel = 0; a_req = '0; a_en = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rr_rotation();
        test_implicit_release();
        test_fixed_priority();
        test_npot_wrap();
        test_en_gating_hold();
        test_reset_mid_grant();
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
